// File: rtl/rv32i_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner encoding,
// the latched access record and default memory latency.
package rv32i_pkg;

  localparam int unsigned MEM_LAT_DEFAULT = 1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  // Access captured at grant time; requester-side changes after grant are ignored.
  typedef struct packed {
    arb_owner_e  owner;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } arb_access_t;

  // Only a data-side store drives byte enables onto the memory.
  function automatic logic [3:0] arb_we_mask(input arb_access_t acc);
    return (acc.owner == OWN_D && acc.we) ? acc.be : 4'b0000;
  endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Down counter timing one memory access: loaded with MEM_LAT-1 at grant, decremented
// while the access is in flight, sticks at zero.
module arb_lat_counter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(MEM_LAT - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store paths; data side has
// fixed priority, one access in flight, one idle cycle between accesses.
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be at least 1");
  end

  arb_state_e  state_q, state_d;
  arb_access_t acc_q, acc_d;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic        capture;

  arb_lat_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_lat_counter (
    .Clk  (Clk),
    .Reset(Reset),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, grant select and all state-decoded outputs.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    capture  = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 4'b0000;
    if_ack   = 1'b0;
    d_ack    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (d_req) begin
          acc_d.owner = OWN_D;
          acc_d.we    = d_we;
          acc_d.be    = d_be;
          acc_d.addr  = d_addr;
          acc_d.wdata = d_wdata;
          cnt_load    = 1'b1;
          state_d     = ARB_ACCESS;
        end else if (if_req) begin
          acc_d.owner = OWN_IF;
          acc_d.we    = 1'b0;
          acc_d.be    = 4'b0000;
          acc_d.addr  = if_addr;
          acc_d.wdata = 32'h0;
          cnt_load    = 1'b1;
          state_d     = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        mem_en  = 1'b1;
        mem_we  = arb_we_mask(acc_q);
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        if_ack  = (acc_q.owner == OWN_IF);
        d_ack   = (acc_q.owner == OWN_D);
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Stores never touch d_rdata, so the last load result stays visible.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else if (capture) begin
      if (acc_q.owner == OWN_IF) begin
        if_rdata_q <= mem_rdata;
      end else if (!acc_q.we) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = acc_q.addr;
  assign mem_wdata = acc_q.wdata;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter at MEM_LAT = 1, 2, 3 against a transaction-level
// model: each grant is a record whose phase follows from its age in cycles.
module tb_mem_port_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        if_req    [N];
  logic [31:0] if_addr   [N];
  logic [31:0] if_rdata  [N];
  logic        if_ack    [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [3:0]  d_be      [N];
  logic [31:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic [31:0] d_rdata   [N];
  logic        d_ack     [N];
  logic        mem_en    [N];
  logic [3:0]  mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic        stall     [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter #(
      .MEM_LAT(g + 1)
    ) u_dut (
      .Clk      (clk),
      .Reset    (rst_n),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_rdata (if_rdata[g]),
      .if_ack   (if_ack[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_be     (d_be[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_rdata  (d_rdata[g]),
      .d_ack    (d_ack[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .stall    (stall[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: one outstanding transaction per instance plus a word memory.
  bit          busy   [N];
  bit          own_d  [N];
  int          gcyc   [N];
  logic [31:0] t_addr [N];
  logic [31:0] t_wdata[N];
  logic [3:0]  t_be   [N];
  bit          t_we   [N];
  logic [31:0] cap_val[N];
  logic [31:0] exp_if_rd[N];
  logic [31:0] exp_d_rd [N];
  bit          e_en   [N];
  logic [3:0]  e_we   [N];
  bit          e_if_ack[N];
  bit          e_d_ack [N];
  logic [31:0] mem_arr[N][16];

  bit          inj_if;
  logic [31:0] inj_if_addr;
  bit          inj_d;
  bit          inj_d_we;
  logic [3:0]  inj_d_be;
  logic [31:0] inj_d_addr;
  logic [31:0] inj_d_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return $urandom & 32'h0000_003f;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      busy[i]      = 1'b0;
      exp_if_rd[i] = 32'h0;
      exp_d_rd[i]  = 32'h0;
      e_en[i]      = 1'b0;
      e_we[i]      = 4'b0;
      e_if_ack[i]  = 1'b0;
      e_d_ack[i]   = 1'b0;
      if_req[i]    = 1'b0;
      d_req[i]     = 1'b0;
    end
  endtask

  task automatic check_outputs(input int i);
    string p;
    p = $sformatf("L%0d_", i + 1);
    check({p, "mem_en"}, 32'(mem_en[i]), 32'(e_en[i]));
    check({p, "mem_we"}, 32'(mem_we[i]), 32'(e_we[i]));
    if (e_en[i]) check({p, "mem_addr"}, mem_addr[i], t_addr[i]);
    if (e_en[i] && t_we[i]) check({p, "mem_wdata"}, mem_wdata[i], t_wdata[i]);
    check({p, "if_ack"}, 32'(if_ack[i]), 32'(e_if_ack[i]));
    check({p, "d_ack"}, 32'(d_ack[i]), 32'(e_d_ack[i]));
    check({p, "if_rdata"}, if_rdata[i], exp_if_rd[i]);
    check({p, "d_rdata"}, d_rdata[i], exp_d_rd[i]);
    check({p, "stall"}, 32'(stall[i]),
          32'((if_req[i] & ~e_if_ack[i]) | (d_req[i] & ~e_d_ack[i])));
  endtask

  task automatic step(input bit rnd);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      int lat;
      int age;
      bit gr_if, gr_d, acc, done;
      lat = i + 1;
      if (busy[i] && (cyc - gcyc[i] > lat + 1)) busy[i] = 1'b0;
      gr_if = busy[i] && !own_d[i];
      gr_d  = busy[i] && own_d[i];

      // Requesters drop req the cycle after ack, otherwise hold until acked.
      if (e_if_ack[i]) begin
        if_req[i] = 1'b0;
      end else if (!if_req[i] && !gr_if) begin
        if (inj_if) begin
          if_req[i]  = 1'b1;
          if_addr[i] = inj_if_addr;
        end else if (rnd && $urandom_range(0, 2) == 0) begin
          if_req[i]  = 1'b1;
          if_addr[i] = rand_addr();
        end
      end else if (rnd && gr_if) begin
        case ($urandom_range(0, 7))
          0: if_req[i] = 1'b0;
          1: if_addr[i] = $urandom;
          default: ;
        endcase
      end

      if (e_d_ack[i]) begin
        d_req[i] = 1'b0;
      end else if (!d_req[i] && !gr_d) begin
        if (inj_d) begin
          d_req[i]   = 1'b1;
          d_we[i]    = inj_d_we;
          d_be[i]    = inj_d_be;
          d_addr[i]  = inj_d_addr;
          d_wdata[i] = inj_d_wdata;
        end else if (rnd && $urandom_range(0, 3) == 0) begin
          d_req[i]   = 1'b1;
          d_we[i]    = 1'($urandom_range(0, 1));
          d_be[i]    = 4'($urandom);
          d_addr[i]  = rand_addr();
          d_wdata[i] = $urandom;
        end
      end else if (rnd && gr_d) begin
        case ($urandom_range(0, 7))
          0: d_req[i] = 1'b0;
          1: begin
            d_addr[i]  = $urandom;
            d_wdata[i] = $urandom;
            d_be[i]    = 4'($urandom);
            d_we[i]    = ~d_we[i];
          end
          default: ;
        endcase
      end

      // Data side wins whenever the arbiter is free.
      if (!busy[i] && (d_req[i] || if_req[i])) begin
        busy[i]    = 1'b1;
        gcyc[i]    = cyc;
        own_d[i]   = d_req[i];
        t_addr[i]  = d_req[i] ? d_addr[i] : if_addr[i];
        t_we[i]    = d_req[i] && d_we[i];
        t_be[i]    = d_be[i];
        t_wdata[i] = d_wdata[i];
      end

      age  = busy[i] ? cyc - gcyc[i] : 0;
      acc  = busy[i] && age >= 1 && age <= lat;
      done = busy[i] && age == lat + 1;

      // Memory data is only valid in the last access cycle; garbage elsewhere.
      if (acc && age == lat) begin
        cap_val[i]   = mem_arr[i][t_addr[i][5:2]];
        mem_rdata[i] = cap_val[i];
      end else begin
        mem_rdata[i] = $urandom;
      end

      if (done) begin
        if (!own_d[i]) begin
          exp_if_rd[i] = cap_val[i];
        end else if (!t_we[i]) begin
          exp_d_rd[i] = cap_val[i];
        end else begin
          for (int b = 0; b < 4; b++) begin
            if (t_be[i][b]) mem_arr[i][t_addr[i][5:2]][8*b +: 8] = t_wdata[i][8*b +: 8];
          end
        end
      end

      e_en[i]     = acc;
      e_we[i]     = (acc && t_we[i]) ? t_be[i] : 4'b0000;
      e_if_ack[i] = done && !own_d[i];
      e_d_ack[i]  = done && own_d[i];
    end
    inj_if = 1'b0;
    inj_d  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) check_outputs(i);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < N; i++) begin
      string p;
      p = $sformatf("%s_L%0d_", tag, i + 1);
      check({p, "mem_en"}, 32'(mem_en[i]), 32'h0);
      check({p, "mem_we"}, 32'(mem_we[i]), 32'h0);
      check({p, "mem_addr"}, mem_addr[i], 32'h0);
      check({p, "if_ack"}, 32'(if_ack[i]), 32'h0);
      check({p, "d_ack"}, 32'(d_ack[i]), 32'h0);
      check({p, "if_rdata"}, if_rdata[i], 32'h0);
      check({p, "d_rdata"}, d_rdata[i], 32'h0);
      check({p, "stall"}, 32'(stall[i]), 32'(if_req[i] | d_req[i]));
    end
  endtask

  initial begin
    int n;
    inj_if = 1'b0;
    inj_d  = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if_addr[i]   = 32'h0;
      d_we[i]      = 1'b0;
      d_be[i]      = 4'h0;
      d_addr[i]    = 32'h0;
      d_wdata[i]   = 32'h0;
      mem_rdata[i] = 32'h0;
      for (int w = 0; w < 16; w++) mem_arr[i][w] = $urandom;
      mem_arr[i][4] = 32'h0050_0093;
      mem_arr[i][8] = 32'h00a0_0113;
      mem_arr[i][0] = 32'h1234_5678;
      mem_arr[i][1] = 32'hcafe_f00d;
    end
    clear_model();
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;

    // Lone fetch of 0x10.
    inj_if = 1'b1;
    inj_if_addr = 32'h10;
    repeat (7) step(1'b0);
    for (int i = 0; i < N; i++) check($sformatf("L%0d_fetch10", i + 1), if_rdata[i], 32'h0050_0093);

    // Fetch and load collide: load goes first.
    inj_if = 1'b1;
    inj_if_addr = 32'h20;
    inj_d = 1'b1;
    inj_d_we = 1'b0;
    inj_d_be = 4'hf;
    inj_d_addr = 32'h100;
    inj_d_wdata = 32'h0;
    repeat (12) step(1'b0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("L%0d_load100", i + 1), d_rdata[i], 32'h1234_5678);
      check($sformatf("L%0d_fetch20", i + 1), if_rdata[i], 32'h00a0_0113);
    end

    // Partial store, then read the word back.
    inj_d = 1'b1;
    inj_d_we = 1'b1;
    inj_d_be = 4'b0011;
    inj_d_addr = 32'h204;
    inj_d_wdata = 32'hdead_beef;
    repeat (7) step(1'b0);
    for (int i = 0; i < N; i++) check($sformatf("L%0d_store_keeps_rd", i + 1), d_rdata[i], 32'h1234_5678);
    inj_d = 1'b1;
    inj_d_we = 1'b0;
    inj_d_addr = 32'h204;
    repeat (7) step(1'b0);
    for (int i = 0; i < N; i++) check($sformatf("L%0d_load204", i + 1), d_rdata[i], 32'hcafe_beef);

    repeat (3000) step(1'b1);

    // Reset in the middle of a MEM_LAT=3 access.
    n = 0;
    while (!(busy[2] && (cyc - gcyc[2] == 1)) && n < 500) begin
      step(1'b1);
      n++;
    end
    check("rst_window_found", 32'(n < 500), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    clear_model();
    @(posedge clk);
    @(negedge clk);
    check_reset_state("inrst");
    rst_n = 1'b1;

    repeat (1500) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
